dvp_tx: RTL

DVP_TX -- requirements
Module: dvp_tx

---
 rtl/dvp_tx_pkg.sv | 20 ++
 rtl/dvp_tim_cnt.sv | 26 ++
 rtl/dvp_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dvp_tx_pkg.sv
// Shared constants and state encoding for the DVP byte transmitter.
// Default frame geometry lives here so every user agrees on it.
package dvp_tx_pkg;

    localparam int H_AP_DEF = 640;
    localparam int V_AP_DEF = 480;
    localparam int PX_W     = 12;
    localparam int LN_W     = 10;
    localparam int TIM_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VFP,
        S_ACT,
        S_HBL,
        S_VBP
    } state_t;

endpackage

// File: rtl/dvp_tim_cnt.sv
// Loadable down-counter timing the blanking intervals.
// done is high once the loaded count has run out.
module dvp_tim_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dvp_tx.sv
// RGB565 pixel stream to 8-bit DVP transmitter with vsync/href framing.
// Each pixel goes out as high byte then low byte on consecutive clocks.
module dvp_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_AP = H_AP_DEF,
    parameter int V_AP = V_AP_DEF,
    parameter int VS_W = 4,
    parameter int V_FP = 16,
    parameter int H_BL = 144,
    parameter int V_BP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] din,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_vld,
    output logic        din_rdy,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  dout,
    output logic        underrun,
    output logic        err
);

    state_t            state;
    logic              ph;
    logic [PX_W-1:0]   px;
    logic [LN_W-1:0]   ln;
    logic [7:0]        lo;
    logic              tim_load;
    logic [TIM_W-1:0]  tim_val;
    logic              tim_done;
    logic              start;
    logic              first;
    logic              line_last;
    logic              frame_last;

    assign start      = enable & din_vld & din_sop;
    assign first      = (px == '0) & (ln == '0);
    assign line_last  = (px == PX_W'(H_AP - 1));
    assign frame_last = line_last & (ln == LN_W'(V_AP - 1));

    always_comb begin
        din_rdy = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  din_rdy = enable & ~din_sop;
                S_ACT:   din_rdy = ~ph;
                default: din_rdy = 1'b0;
            endcase
        end
    end

    // Timer reloads mirror the FSM transitions into each timed state.
    always_comb begin
        tim_load = 1'b0;
        tim_val  = '0;
        case (state)
            S_IDLE: if (start) begin
                tim_load = 1'b1;
                tim_val  = TIM_W'(VS_W - 1);
            end
            S_VSYNC: if (tim_done) begin
                tim_load = 1'b1;
                tim_val  = TIM_W'(V_FP - 1);
            end
            S_ACT: if (ph && line_last) begin
                tim_load = 1'b1;
                tim_val  = frame_last ? TIM_W'(V_BP - 1) : TIM_W'(H_BL - 1);
            end
            default: tim_load = 1'b0;
        endcase
    end

    dvp_tim_cnt #(.W(TIM_W)) u_tim (
        .clk  (clk),
        .rst  (rst),
        .load (tim_load),
        .val  (tim_val),
        .done (tim_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= 1'b0;
            px       <= '0;
            ln       <= '0;
            lo       <= '0;
            vsync    <= 1'b0;
            href     <= 1'b0;
            dout     <= '0;
            underrun <= 1'b0;
            err      <= 1'b0;
        end else begin
            href     <= 1'b0;
            dout     <= '0;
            underrun <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_VSYNC;
                    vsync <= 1'b1;
                end
                S_VSYNC: if (tim_done) begin
                    state <= S_VFP;
                    vsync <= 1'b0;
                end
                S_VFP: if (tim_done) state <= S_ACT;
                S_ACT: begin
                    if (ph) begin
                        href <= 1'b1;
                        dout <= lo;
                        ph   <= 1'b0;
                        if (line_last) begin
                            px <= '0;
                            if (frame_last) begin
                                ln    <= '0;
                                state <= S_VBP;
                            end else begin
                                ln    <= ln + 1'b1;
                                state <= S_HBL;
                            end
                        end else begin
                            px <= px + 1'b1;
                        end
                    end else if (din_vld) begin
                        href <= 1'b1;
                        dout <= din[15:8];
                        lo   <= din[7:0];
                        ph   <= 1'b1;
                        err  <= (din_sop != first) | (din_eop != frame_last);
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                S_HBL: if (tim_done) state <= S_ACT;
                S_VBP: if (tim_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
